// File: rtl/wbuf_pkg.sv
// Shared constants, state encoding and address helper for the weight-buffer write controller.
// Optional build macro used by this slice: WBUF_WRITE_PERF_EN (stall-cycle counter on the top).
package wbuf_pkg;

    localparam int MEM_DATA_WIDTH = 256;
    localparam int BUF_ADDR_WIDTH = 9;
    localparam int BUF_ID_W       = 3;
    localparam int ROW_CNT_W      = 10;

    localparam int NUM_BANKS      = 1 << BUF_ID_W;
    localparam int WRITE_ADDR_W   = BUF_ADDR_WIDTH + BUF_ID_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } wbuf_state_e;

    // Buffer write address: row in the upper bits, bank id in the lower bits.
    function automatic logic [WRITE_ADDR_W-1:0] make_write_addr(
        input logic [BUF_ADDR_WIDTH-1:0] row,
        input logic [BUF_ID_W-1:0]       bank
    );
        return {row, bank};
    endfunction

endpackage

// File: rtl/wbuf_write_ctrl_if.sv
// Command, beat stream and buffer write port of the weight-buffer write controller.
// Handshakes: a command or beat transfers on a rising clk edge where valid && ready are both high.
interface wbuf_write_ctrl_if
    import wbuf_pkg::*;
();

    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [BUF_ADDR_WIDTH-1:0] cmd_base_addr;
    logic [ROW_CNT_W-1:0]      cmd_num_rows;

    logic                      s_valid;
    logic                      s_ready;
    logic [MEM_DATA_WIDTH-1:0] s_data;

    logic                      mem_write_req;
    logic [WRITE_ADDR_W-1:0]   mem_write_addr;
    logic [MEM_DATA_WIDTH-1:0] mem_write_data;

    // Upstream side: issues commands and beats, observes the buffer write port.
    modport master (
        output cmd_valid, cmd_base_addr, cmd_num_rows,
        output s_valid, s_data,
        input  cmd_ready, s_ready,
        input  mem_write_req, mem_write_addr, mem_write_data
    );

    // Controller side.
    modport slave (
        input  cmd_valid, cmd_base_addr, cmd_num_rows,
        input  s_valid, s_data,
        output cmd_ready, s_ready,
        output mem_write_req, mem_write_addr, mem_write_data
    );

endinterface

// File: rtl/wbuf_addr_gen.sv
// Bank/row counters for one load command: produces the current row address (base + row,
// wrapping modulo the buffer depth), the current bank and a flag marking the final beat.
module wbuf_addr_gen
    import wbuf_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [BUF_ADDR_WIDTH-1:0] base_addr,
    input  logic [ROW_CNT_W-1:0]      num_rows,
    input  logic                      advance,
    output logic [BUF_ADDR_WIDTH-1:0] row_addr,
    output logic [BUF_ID_W-1:0]       bank,
    output logic                      last_beat
);

    localparam logic [BUF_ID_W-1:0]  BANK_MAX = BUF_ID_W'(NUM_BANKS - 1);
    localparam logic [BUF_ID_W-1:0]  BANK_ONE = BUF_ID_W'(1);
    localparam logic [ROW_CNT_W-1:0] ROW_ONE  = ROW_CNT_W'(1);

    logic [BUF_ADDR_WIDTH-1:0] base_q;
    logic [ROW_CNT_W-1:0]      rows_q;
    logic [ROW_CNT_W-1:0]      row_cnt;
    logic [BUF_ID_W-1:0]       bank_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q   <= '0;
            rows_q   <= '0;
            row_cnt  <= '0;
            bank_cnt <= '0;
        end else if (load) begin
            base_q   <= base_addr;
            rows_q   <= num_rows;
            row_cnt  <= '0;
            bank_cnt <= '0;
        end else if (advance) begin
            // Bank is the fast index; the row moves on when the bank wraps.
            bank_cnt <= bank_cnt + BANK_ONE;
            if (bank_cnt == BANK_MAX) begin
                row_cnt <= row_cnt + ROW_ONE;
            end
        end
    end

    // Only the low bits of the row count matter: the sum wraps at the buffer depth.
    assign row_addr  = base_q + row_cnt[BUF_ADDR_WIDTH-1:0];
    assign bank      = bank_cnt;
    assign last_beat = (row_cnt == rows_q - ROW_ONE) && (bank_cnt == BANK_MAX);

endmodule

// File: rtl/wbuf_write_ctrl.sv
// Write-side controller for the weight buffer: takes a load command and a beat stream and
// issues one buffer write per beat, banks interleaved. Optional macro: WBUF_WRITE_PERF_EN.
module wbuf_write_ctrl
    import wbuf_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    wbuf_write_ctrl_if.slave    bus,
    output logic                busy,
    output logic                done,
    output wbuf_state_e         dbg_state
`ifdef WBUF_WRITE_PERF_EN
    ,
    output logic [31:0]         perf_stall_cycles
`endif
);

    wbuf_state_e               state;
    logic                      cmd_fire;
    logic                      beat_fire;
    logic [BUF_ADDR_WIDTH-1:0] row_addr;
    logic [BUF_ID_W-1:0]       bank;
    logic                      last_beat;

    assign cmd_fire  = bus.cmd_valid && bus.cmd_ready;
    assign beat_fire = bus.s_valid && bus.s_ready;

    wbuf_addr_gen u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (cmd_fire),
        .base_addr (bus.cmd_base_addr),
        .num_rows  (bus.cmd_num_rows),
        .advance   (beat_fire),
        .row_addr  (row_addr),
        .bank      (bank),
        .last_beat (last_beat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= ST_IDLE;
            bus.cmd_ready      <= 1'b1;
            bus.s_ready        <= 1'b0;
            bus.mem_write_req  <= 1'b0;
            bus.mem_write_addr <= '0;
            bus.mem_write_data <= '0;
            done               <= 1'b0;
        end else begin
            // Each accepted beat becomes exactly one write in the following cycle.
            bus.mem_write_req <= beat_fire;
            done              <= 1'b0;
            if (beat_fire) begin
                bus.mem_write_addr <= make_write_addr(row_addr, bank);
                bus.mem_write_data <= bus.s_data;
            end

            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        bus.cmd_ready <= 1'b0;
                        if (bus.cmd_num_rows == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= ST_LOAD;
                            bus.s_ready <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    // done rises together with the write of the final beat.
                    if (beat_fire && last_beat) begin
                        state       <= ST_DONE;
                        bus.s_ready <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state         <= ST_IDLE;
                    bus.cmd_ready <= 1'b1;
                end
                default: begin
                    state         <= ST_IDLE;
                    bus.cmd_ready <= 1'b1;
                    bus.s_ready   <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

`ifdef WBUF_WRITE_PERF_EN
    // Stall cycles of the most recent command; holds after it completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cycles <= '0;
        end else if (cmd_fire) begin
            perf_stall_cycles <= '0;
        end else if ((state == ST_LOAD) && !bus.s_valid && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wbuf_write_ctrl.sv
// Directed bench for wbuf_write_ctrl: a transaction-level model of expected writes/done pulses
// checked every cycle, plus literal checks on addresses, timing and reset behaviour.
module tb_wbuf_write_ctrl;
    import wbuf_pkg::*;

    localparam int EXP_W = 2 + WRITE_ADDR_W + MEM_DATA_WIDTH;

    logic        clk;
    logic        reset;
    logic        busy;
    logic        done;
    wbuf_state_e dbg_state;
`ifdef WBUF_WRITE_PERF_EN
    logic [31:0] perf_stall_cycles;
`endif

    wbuf_write_ctrl_if bus ();

    wbuf_write_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
`ifdef WBUF_WRITE_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    // ---------------- clock / reset ----------------
    int cyc_cnt = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    // entry: {is_write, is_last, addr, data}
    logic [EXP_W-1:0]          exp_q[$];
    logic [WRITE_ADDR_W-1:0]   obs_addr[$];
    logic [EXP_W-1:0]          cur_e;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int hs_cyc = 0;
    int first_acc_cyc = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] beat_data(input int tag, input int idx);
        logic [31:0] w;
        w = {tag[15:0], idx[15:0]};
        return {8{w}};
    endfunction

    // Expected writes of one command: bank fastest, then row; row wraps modulo the buffer depth.
    task automatic model_cmd(input int base, input int rows, input int tag);
        logic [BUF_ADDR_WIDTH-1:0] row;
        logic [BUF_ID_W-1:0]       bnk;
        logic                      last;
        if (rows == 0) begin
            exp_q.push_back({1'b0, 1'b1, {WRITE_ADDR_W{1'b0}}, {MEM_DATA_WIDTH{1'b0}}});
        end
        for (int r = 0; r < rows; r++) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                row  = BUF_ADDR_WIDTH'((base + r) % (1 << BUF_ADDR_WIDTH));
                bnk  = BUF_ID_W'(b);
                last = (r == rows - 1) && (b == NUM_BANKS - 1);
                exp_q.push_back({1'b1, last, row, bnk, beat_data(tag, r * NUM_BANKS + b)});
            end
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!reset && (bus.mem_write_req || done)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got req=%0b done=%0b, expected no activity",
                         bus.mem_write_req, done);
            end else begin
                cur_e = exp_q.pop_front();
                check("write_req", 256'(bus.mem_write_req), 256'(cur_e[EXP_W-1]));
                check("done_with_last", 256'(done), 256'(cur_e[EXP_W-2]));
                if (cur_e[EXP_W-1]) begin
                    check("write_addr", 256'(bus.mem_write_addr),
                          256'(cur_e[MEM_DATA_WIDTH +: WRITE_ADDR_W]));
                    check("write_data", bus.mem_write_data, cur_e[MEM_DATA_WIDTH-1:0]);
                end
            end
        end
        if (bus.mem_write_req) obs_addr.push_back(bus.mem_write_addr);
        if (done) begin
            done_cnt++;
            done_cyc = cyc_cnt;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input int base, input int rows, input int tag);
        int n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("cmd_ready_wait", 256'(bus.cmd_ready), 256'(1));
        model_cmd(base, rows, tag);
        bus.cmd_valid     = 1'b1;
        bus.cmd_base_addr = BUF_ADDR_WIDTH'(base);
        bus.cmd_num_rows  = ROW_CNT_W'(rows);
        hs_cyc = cyc_cnt;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic stream(input int tag, input int start, input int n, input bit toggle);
        int k = 0;
        int cyc = 0;
        bit vld;
        bit fire;
        while (k < n && cyc < 200) begin
            vld = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.s_valid = vld;
            bus.s_data  = beat_data(tag, start + k);
            fire = vld && bus.s_ready;
            if (fire && k == 0 && start == 0) first_acc_cyc = cyc_cnt;
            @(posedge clk); #1;
            if (fire) k++;
            cyc++;
        end
        bus.s_valid = 1'b0;
        check("stream_beats_accepted", 256'(k), 256'(n));
    endtask

    task automatic wait_done();
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("done_seen", 256'(done_cnt - start), 256'(1));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, 256'(bus.cmd_ready), 256'(1));
        check({tag, "_s_ready"}, 256'(bus.s_ready), 256'(0));
        check({tag, "_req"}, 256'(bus.mem_write_req), 256'(0));
        check({tag, "_addr"}, 256'(bus.mem_write_addr), 256'(0));
        check({tag, "_data"}, bus.mem_write_data, 256'(0));
        check({tag, "_busy"}, 256'(busy), 256'(0));
        check({tag, "_done"}, 256'(done), 256'(0));
        check({tag, "_state"}, 256'(dbg_state), 256'(0));
    endtask

    // ---------------- directed tests ----------------
    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_base_addr = '0;
        bus.cmd_num_rows = '0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // basic load: base 0, 2 rows, beats back to back
        obs_addr.delete();
        send_cmd(0, 2, 1);
        check("basic_busy", 256'(busy), 256'(1));
        check("basic_state_load", 256'(dbg_state), 256'(1));
        stream(1, 0, 16, 1'b0);
        wait_done();
        check("basic_write_count", 256'(obs_addr.size()), 256'(16));
        check("basic_addr0", 256'(obs_addr[0]), 256'(12'h000));
        check("basic_addr7", 256'(obs_addr[7]), 256'(12'h007));
        check("basic_addr8", 256'(obs_addr[8]), 256'(12'h008));
        check("basic_addr15", 256'(obs_addr[15]), 256'(12'h00F));
        check("basic_done_latency", 256'(done_cyc - first_acc_cyc), 256'(16));

        // zero rows: no writes, done the cycle after the handshake
        obs_addr.delete();
        send_cmd(7, 0, 2);
        wait_done();
        check("zero_write_count", 256'(obs_addr.size()), 256'(0));
        check("zero_done_latency", 256'(done_cyc - hs_cyc), 256'(1));
        check("zero_cmd_ready_in_done", 256'(bus.cmd_ready), 256'(0));
        @(posedge clk); #1;
        check("zero_cmd_ready_back", 256'(bus.cmd_ready), 256'(1));
        check("zero_done_cleared", 256'(done), 256'(0));

        // stalls: s_valid toggling, one row
        obs_addr.delete();
        send_cmd(20, 1, 3);
        stream(3, 0, 8, 1'b1);
        wait_done();
        check("stall_write_count", 256'(obs_addr.size()), 256'(8));
        check("stall_addr_first", 256'(obs_addr[0]), 256'(12'h0A0));
        check("stall_addr_last", 256'(obs_addr[7]), 256'(12'h0A7));
`ifdef WBUF_WRITE_PERF_EN
        @(posedge clk); #1;
        check("stall_perf_cycles", 256'(perf_stall_cycles), 256'(7));
`endif

        // row wrap: base 511, 2 rows
        obs_addr.delete();
        send_cmd(511, 2, 4);
        stream(4, 0, 16, 1'b0);
        wait_done();
        check("wrap_write_count", 256'(obs_addr.size()), 256'(16));
        check("wrap_addr0", 256'(obs_addr[0]), 256'(12'hFF8));
        check("wrap_addr7", 256'(obs_addr[7]), 256'(12'hFFF));
        check("wrap_addr8", 256'(obs_addr[8]), 256'(12'h000));
        check("wrap_addr15", 256'(obs_addr[15]), 256'(12'h007));

        // second command while busy is ignored
        obs_addr.delete();
        send_cmd(5, 1, 5);
        bus.cmd_valid = 1'b1;
        bus.cmd_base_addr = 9'd100;
        bus.cmd_num_rows = 10'd3;
        stream(5, 0, 4, 1'b0);
        check("busy_cmd_ready_low", 256'(bus.cmd_ready), 256'(0));
        check("busy_flag", 256'(busy), 256'(1));
        bus.cmd_valid = 1'b0;
        stream(5, 4, 4, 1'b0);
        wait_done();
        repeat (4) @(posedge clk);
        #1;
        check("busy_write_count", 256'(obs_addr.size()), 256'(8));
        check("busy_addr_first", 256'(obs_addr[0]), 256'(12'h028));
        check("busy_idle_after", 256'(busy), 256'(0));

        // reset in the middle of a load
        obs_addr.delete();
        send_cmd(40, 2, 6);
        stream(6, 0, 5, 1'b0);
        @(negedge clk); #1;
        check("rst_writes_before", 256'(obs_addr.size()), 256'(5));
        reset = 1'b1;
        #1;
        exp_q.delete();
        check_reset_values("midreset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        obs_addr.delete();
        send_cmd(3, 1, 7);
        stream(7, 0, 8, 1'b0);
        wait_done();
        check("rst_new_write_count", 256'(obs_addr.size()), 256'(8));
        check("rst_new_addr0", 256'(obs_addr[0]), 256'(12'h018));
        check("rst_new_addr7", 256'(obs_addr[7]), 256'(12'h01F));

        repeat (3) @(posedge clk);
        #1;
        check("model_queue_drained", 256'(exp_q.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
